// File: rtl/mutation_arbiter_sv.sv
// Round-robin scheduler sharing one mutation engine among NUM_REQ lanes,
// with a watchdog that returns the unmutated child when the engine stalls.
module mutation_arbiter_sv #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GENE_LEN    = 12,
  parameter int unsigned CHAR_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned GW = GENE_LEN * CHAR_WIDTH,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*GW-1:0] req_gene,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [7:0]            cfg_thresh,
  output logic                  mu_start,
  output logic [GW-1:0]         mu_child,
  output logic [7:0]            mu_thresh,
  input  logic [GW-1:0]         mu_mutant,
  input  logic                  mu_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [GW-1:0]         rsp_gene,
  output logic                  rsp_err,
  output logic [15:0]           served_cnt,
  output logic [7:0]            err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  always_comb begin
    int unsigned base;
    int unsigned idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    base    = {{(32-IW){1'b0}}, ptr};
    idx     = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (base + off) % NUM_REQ;
      if (!gnt_any && req_valid[idx[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IW-1:0];
      end
    end
  end

  // Grant is gated by reset so nothing is offered while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && gnt_any)
      req_ready[gnt_idx] = 1'b1;
  end

  assign mu_start  = (state == S_START);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      timer      <= '0;
      mu_child   <= '0;
      mu_thresh  <= '0;
      rsp_id     <= '0;
      rsp_gene   <= '0;
      rsp_err    <= 1'b0;
      served_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            mu_child  <= req_gene[gnt_idx*GW +: GW];
            rsp_id    <= gnt_idx;
            mu_thresh <= cfg_thresh;
            ptr       <= gnt_idx;
            state     <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mu_done) begin
            rsp_gene <= mu_mutant;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            rsp_gene <= mu_child;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            if (served_cnt != '1)
              served_cnt <= served_cnt + 1'b1;
            if (rsp_err && (err_cnt != '1))
              err_cnt <= err_cnt + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
